wbc_rr_intercon: RTL and testbench

//  Parametrised successor to the shared-bus control WISHBONE interconnect.

---
 rtl/wbc_rr_intercon.sv | 183 ++++++++++++++++++
 tb/tb_wbc_rr_intercon.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbc_rr_intercon.sv
// Round-robin WISHBONE control-bus interconnect: NUM_MASTERS masters onto NUM_SLAVES slaves,
// grant held while cyc stays high, bad addresses and hung slaves terminated with err.
module wbc_rr_intercon #(
   parameter int unsigned NUM_MASTERS    = 3,
   parameter int unsigned NUM_SLAVES     = 4,
   parameter int unsigned DAT_WIDTH      = 32,
   parameter int unsigned ADR_WIDTH      = 20,
   parameter int unsigned SLV_ADR_WIDTH  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [NUM_MASTERS-1:0]                m_cyc_i,
   input  logic [NUM_MASTERS-1:0]                m_stb_i,
   input  logic [NUM_MASTERS-1:0]                m_we_i,
   input  logic [NUM_MASTERS*ADR_WIDTH-1:0]      m_adr_i,
   input  logic [NUM_MASTERS*DAT_WIDTH-1:0]      m_dat_i,
   input  logic [NUM_MASTERS*(DAT_WIDTH/8)-1:0]  m_sel_i,
   output logic [DAT_WIDTH-1:0]                  m_dat_o,
   output logic [NUM_MASTERS-1:0]                m_ack_o,
   output logic [NUM_MASTERS-1:0]                m_err_o,
   output logic [NUM_MASTERS-1:0]                m_rty_o,
   output logic [NUM_SLAVES-1:0]                 s_cyc_o,
   output logic [NUM_SLAVES-1:0]                 s_stb_o,
   output logic                                  s_we_o,
   output logic [SLV_ADR_WIDTH-1:0]              s_adr_o,
   output logic [DAT_WIDTH-1:0]                  s_dat_o,
   output logic [DAT_WIDTH/8-1:0]                s_sel_o,
   input  logic [NUM_SLAVES*DAT_WIDTH-1:0]       s_dat_i,
   input  logic [NUM_SLAVES-1:0]                 s_ack_i,
   input  logic [NUM_SLAVES-1:0]                 s_err_i,
   input  logic [NUM_SLAVES-1:0]                 s_rty_i,
   output logic [NUM_MASTERS-1:0]                grant_o,
   output logic [15:0]                           timeout_count_o
);

   localparam int unsigned NM   = NUM_MASTERS;
   localparam int unsigned NS   = NUM_SLAVES;
   localparam int unsigned DW   = DAT_WIDTH;
   localparam int unsigned AW   = ADR_WIDTH;
   localparam int unsigned SAW  = SLV_ADR_WIDTH;
   localparam int unsigned SW   = DAT_WIDTH / 8;
   localparam int unsigned IW   = (NM > 1) ? $clog2(NM) : 1;
   localparam int unsigned DECW = AW - SAW;
   localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   rr_q, rr_d;
   logic [IW-1:0]   gidx_q, gidx_d;
   logic [NM-1:0]   grant_q, grant_d;
   logic [15:0]     tmo_cnt_q, tmo_cnt_d;
   logic [15:0]     tmo_total_q, tmo_total_d;
   logic            bad_err_q, bad_err_d;

   logic            busy, g_cyc, g_stb, g_we;
   logic [AW-1:0]   g_adr;
   logic [DW-1:0]   g_dat;
   logic [SW-1:0]   g_sel;
   logic [DECW-1:0] dec;
   logic            dec_ok, dec_valid;
   logic            sl_ack, sl_err, sl_rty;
   logic [DW-1:0]   sl_dat;
   logic            resp, tmo_pulse;
   logic [NM-1:0]   req_rot;
   logic [IW-1:0]   off, pick;
   int unsigned     pick_sum;

   // Granted master view, slave decode and response routing
   always_comb begin
      busy      = (state_q == StBusy);
      g_cyc     = busy & m_cyc_i[gidx_q];
      g_stb     = g_cyc & m_stb_i[gidx_q];
      g_we      = m_we_i[gidx_q];
      g_adr     = m_adr_i[gidx_q*AW +: AW];
      g_dat     = m_dat_i[gidx_q*DW +: DW];
      g_sel     = m_sel_i[gidx_q*SW +: SW];
      dec       = g_adr[AW-1:SAW];
      dec_ok    = (32'(dec) < NS);
      dec_valid = busy & dec_ok;
      sl_ack    = 1'b0;
      sl_err    = 1'b0;
      sl_rty    = 1'b0;
      sl_dat    = '0;
      for (int unsigned s = 0; s < NS; s++) begin
         if (dec_valid && (32'(dec) == s)) begin
            sl_ack = s_ack_i[s];
            sl_err = s_err_i[s];
            sl_rty = s_rty_i[s];
            sl_dat = s_dat_i[s*DW +: DW];
         end
      end
      resp      = sl_ack | sl_err | sl_rty | bad_err_q;
      tmo_pulse = g_stb & ~resp & (tmo_cnt_q == TmoLast);
   end

   always_comb begin
      s_cyc_o = '0;
      s_stb_o = '0;
      for (int unsigned s = 0; s < NS; s++) begin
         if (dec_valid && (32'(dec) == s)) begin
            s_cyc_o[s] = g_cyc;
            s_stb_o[s] = g_stb & ~tmo_pulse;
         end
      end
      s_we_o  = busy & g_we;
      s_adr_o = busy ? g_adr[SAW-1:0] : '0;
      s_dat_o = busy ? g_dat : '0;
      s_sel_o = busy ? g_sel : '0;
      m_dat_o = sl_dat;
      // grant_q is zero when idle, so non-granted masters never see a response
      m_ack_o = grant_q & {NM{sl_ack & ~sl_err}};
      m_err_o = grant_q & {NM{sl_err | tmo_pulse | bad_err_q}};
      m_rty_o = grant_q & {NM{sl_rty & ~sl_ack & ~sl_err}};
   end

   // Round-robin pick: rotate requests so the pointer sits at bit 0, take the lowest set bit
   always_comb begin
      req_rot = NM'({m_cyc_i, m_cyc_i} >> rr_q);
      off     = '0;
      for (int i = int'(NM) - 1; i >= 0; i--) begin
         if (req_rot[i]) off = IW'(i);
      end
      pick_sum = 32'(rr_q) + 32'(off);
      if (pick_sum >= NM) pick_sum = pick_sum - NM;
      pick = IW'(pick_sum);
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      gidx_d      = gidx_q;
      grant_d     = grant_q;
      tmo_total_d = tmo_total_q;
      unique case (state_q)
         StIdle: begin
            if (|m_cyc_i) begin
               gidx_d        = pick;
               grant_d       = '0;
               grant_d[pick] = 1'b1;
               state_d       = StBusy;
            end
         end
         StBusy: begin
            if (!m_cyc_i[gidx_q]) begin
               state_d = StIdle;
               grant_d = '0;
               rr_d    = (gidx_q == IW'(NM - 1)) ? '0 : gidx_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      tmo_cnt_d = (g_stb && !resp && !tmo_pulse) ? tmo_cnt_q + 16'd1 : 16'd0;
      if (tmo_pulse && (tmo_total_q != 16'hFFFF)) tmo_total_d = tmo_total_q + 16'd1;
      // The stb still high while the err pulse is out belongs to the transfer being terminated
      bad_err_d = g_stb & ~dec_ok & ~bad_err_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         rr_q        <= '0;
         gidx_q      <= '0;
         grant_q     <= '0;
         tmo_cnt_q   <= '0;
         tmo_total_q <= '0;
         bad_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         gidx_q      <= gidx_d;
         grant_q     <= grant_d;
         tmo_cnt_q   <= tmo_cnt_d;
         tmo_total_q <= tmo_total_d;
         bad_err_q   <= bad_err_d;
      end
   end

   assign grant_o         = grant_q;
   assign timeout_count_o = tmo_total_q;

endmodule

// File: tb/tb_wbc_rr_intercon.sv
// Bench for wbc_rr_intercon: directed scenarios followed by randomized request rounds
// checked against a request-set / round-robin-pointer model.
module tb_wbc_rr_intercon;
   localparam int NM = 3, NS = 4, DW = 32, AW = 20, SAW = 16, TMO = 8;

   logic clk;
   logic rst;
   logic [NM-1:0]      m_cyc, m_stb, m_we;
   logic [NM*AW-1:0]   m_adr;
   logic [NM*DW-1:0]   m_dat;
   logic [NM*4-1:0]    m_sel;
   logic [DW-1:0]      m_dat_o;
   logic [NM-1:0]      m_ack, m_err, m_rty;
   logic [NS-1:0]      s_cyc, s_stb;
   logic               s_we;
   logic [SAW-1:0]     s_adr;
   logic [DW-1:0]      s_dat_o;
   logic [3:0]         s_sel;
   logic [NS*DW-1:0]   s_dat_i;
   logic [NS-1:0]      s_ack, s_err, s_rty;
   logic [NM-1:0]      grant;
   logic [15:0]        tcount;

   int checks   = 0;
   int failures = 0;
   int ptr_m    = 0;

   wbc_rr_intercon #(
      .NUM_MASTERS   (NM),
      .NUM_SLAVES    (NS),
      .DAT_WIDTH     (DW),
      .ADR_WIDTH     (AW),
      .SLV_ADR_WIDTH (SAW),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .m_cyc_i        (m_cyc),
      .m_stb_i        (m_stb),
      .m_we_i         (m_we),
      .m_adr_i        (m_adr),
      .m_dat_i        (m_dat),
      .m_sel_i        (m_sel),
      .m_dat_o        (m_dat_o),
      .m_ack_o        (m_ack),
      .m_err_o        (m_err),
      .m_rty_o        (m_rty),
      .s_cyc_o        (s_cyc),
      .s_stb_o        (s_stb),
      .s_we_o         (s_we),
      .s_adr_o        (s_adr),
      .s_dat_o        (s_dat_o),
      .s_sel_o        (s_sel),
      .s_dat_i        (s_dat_i),
      .s_ack_i        (s_ack),
      .s_err_i        (s_err),
      .s_rty_i        (s_rty),
      .grant_o        (grant),
      .timeout_count_o(tcount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   // Model arbiter: first requester at or after the pointer, wrapping
   function automatic int pick(input logic [NM-1:0] req, input int ptr);
      for (int i = 0; i < NM; i++) begin
         if (req[(ptr + i) % NM]) return (ptr + i) % NM;
      end
      return -1;
   endfunction

   // kind: 0 ack, 1 err, 2 rty, 3 ack+err, 4 ack+rty
   task automatic xfer(input int m, input logic we, input int sl, input logic [15:0] lo,
                       input logic [31:0] wd, input logic [31:0] rd, input logic [3:0] sel,
                       input int dly, input int kind);
      logic a, e, r;
      a = (kind == 0) || (kind == 3) || (kind == 4);
      e = (kind == 1) || (kind == 3);
      r = (kind == 2) || (kind == 4);
      m_stb[m] = 1'b1;
      m_we[m]  = we;
      m_adr[m*AW +: AW] = {4'(sl), lo};
      m_dat[m*DW +: DW] = wd;
      m_sel[m*4 +: 4]   = sel;
      #1;
      chk("xfer_grant", 32'(grant), 32'(1 << m));
      chk("s_cyc", 32'(s_cyc), 32'(1 << sl));
      chk("s_stb", 32'(s_stb), 32'(1 << sl));
      chk("s_adr", 32'(s_adr), 32'(lo));
      chk("s_we", 32'(s_we), 32'(we));
      chk("s_dat", s_dat_o, wd);
      chk("s_sel", 32'(s_sel), 32'(sel));
      for (int k = 0; k < dly; k++) begin
         nxt();
         #1;
         chk("wait_rsp", 32'({m_ack, m_err, m_rty}), 32'(0));
      end
      s_ack[sl] = a;
      s_err[sl] = e;
      s_rty[sl] = r;
      s_dat_i[sl*DW +: DW] = rd;
      #1;
      chk("m_ack", 32'(m_ack), (a && !e) ? 32'(1 << m) : 32'(0));
      chk("m_err", 32'(m_err), e ? 32'(1 << m) : 32'(0));
      chk("m_rty", 32'(m_rty), (r && !a && !e) ? 32'(1 << m) : 32'(0));
      chk("m_dat", m_dat_o, rd);
      nxt();
      s_ack    = '0;
      s_err    = '0;
      s_rty    = '0;
      m_stb[m] = 1'b0;
   endtask

   // Serve a set of requesters to completion; optional late requests join after releases
   task automatic serve(input logic [NM-1:0] req, input logic [NM-1:0] late, input int nref,
                        input int ntr, input bit rnd);
      logic [NM-1:0] pending, lm;
      int g, n, refills;
      pending = req;
      refills = nref;
      m_cyc   = m_cyc | req;
      while (pending != '0) begin
         nxt();
         #1;
         g = pick(pending, ptr_m);
         chk("grant", 32'(grant), 32'(1 << g));
         n = rnd ? int'($urandom_range(1, 3)) : ntr;
         for (int t = 0; t < n; t++) begin
            if (rnd)
               xfer(g, 1'($urandom_range(0, 1)), int'($urandom_range(0, NS - 1)), 16'($urandom),
                    $urandom, $urandom, 4'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 4)));
            else
               xfer(g, 1'b1, g, 16'h0100 + 16'(t), 32'hA000_0000 + 32'(g), 32'h5A5A_0000 + 32'(t),
                    4'hF, 1, 0);
         end
         m_cyc[g]   = 1'b0;
         pending[g] = 1'b0;
         ptr_m      = (g + 1) % NM;
         nxt();
         #1;
         chk("dead_grant", 32'(grant), 32'(0));
         chk("dead_s_cyc", 32'(s_cyc), 32'(0));
         if (refills > 0) begin
            lm      = rnd ? NM'($urandom_range(0, 7)) : late;
            pending = pending | lm;
            m_cyc   = m_cyc | lm;
            refills--;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
      s_dat_i = '0; s_ack = '0; s_err = '0; s_rty = '0;
      nxt(); nxt();
      #1;
      chk("rst_grant", 32'(grant), 32'(0));
      chk("rst_tcount", 32'(tcount), 32'(0));
      chk("rst_s_cyc", 32'(s_cyc), 32'(0));
      chk("rst_m_rsp", 32'({m_ack, m_err, m_rty}), 32'(0));
      chk("rst_m_dat", m_dat_o, 32'(0));
      rst = 1'b0;

      // Single read from m0 to slave 1
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0 +: AW] = 20'h1_0004;
      #1;
      chk("t1_no_grant_yet", 32'(grant), 32'(0));
      nxt(); #1;
      chk("t1_grant", 32'(grant), 32'h1);
      chk("t1_s_cyc", 32'(s_cyc), 32'h2);
      chk("t1_s_adr", 32'(s_adr), 32'h0004);
      s_ack[1] = 1'b1; s_dat_i[DW +: DW] = 32'hDEAD_BEEF;
      #1;
      chk("t1_m_ack", 32'(m_ack), 32'h1);
      chk("t1_m_dat", m_dat_o, 32'hDEAD_BEEF);
      nxt();
      s_ack = '0; m_stb = '0; m_cyc = '0; m_adr = '0;
      nxt(); #1;
      chk("t1_release", 32'(grant), 32'(0));

      // Reset so the pointer restarts at 0, then three masters contend
      rst = 1'b1;
      nxt();
      rst = 1'b0;
      ptr_m = 0;
      serve(3'b111, 3'b001, 1, 1, 1'b0);

      // m1 holds its grant over three transfers while m0 waits
      serve(3'b011, 3'b000, 0, 3, 1'b0);

      // Invalid decode from m2
      m_cyc[2] = 1'b1;
      nxt(); #1;
      chk("t4_grant", 32'(grant), 32'h4);
      m_stb[2] = 1'b1; m_we[2] = 1'b1; m_adr[2*AW +: AW] = 20'hF_0000;
      #1;
      chk("t4_no_s_cyc", 32'(s_cyc), 32'(0));
      chk("t4_no_s_stb", 32'(s_stb), 32'(0));
      chk("t4_err_not_yet", 32'(m_err), 32'(0));
      nxt(); #1;
      chk("t4_err", 32'(m_err), 32'h4);
      nxt(); #1;
      chk("t4_err_once", 32'(m_err), 32'(0));
      m_stb[2] = 1'b0; m_cyc[2] = 1'b0; m_we[2] = 1'b0; m_adr = '0;
      nxt(); #1;
      chk("t4_release", 32'(grant), 32'(0));
      ptr_m = 0;

      // Hung slave 3: forced err on the TMO-th stb cycle
      m_cyc[0] = 1'b1;
      nxt(); #1;
      chk("t5_grant", 32'(grant), 32'h1);
      m_stb[0] = 1'b1; m_adr[0 +: AW] = 20'h3_0010;
      for (int k = 1; k <= TMO; k++) begin
         #1;
         if (k < TMO) begin
            chk("t5_no_err", 32'(m_err), 32'(0));
            chk("t5_stb", 32'(s_stb), 32'h8);
            nxt();
         end else begin
            chk("t5_tmo_err", 32'(m_err), 32'h1);
            chk("t5_stb_gated", 32'(s_stb), 32'(0));
         end
      end
      nxt(); #1;
      chk("t5_tcount", 32'(tcount), 32'h1);
      chk("t5_err_done", 32'(m_err), 32'(0));
      m_stb[0] = 1'b0; m_cyc[0] = 1'b0;
      nxt(); #1;
      chk("t5_release", 32'(grant), 32'(0));

      // Same, but the slave acks on the TMO-th cycle
      m_cyc[0] = 1'b1;
      nxt(); #1;
      chk("t5b_grant", 32'(grant), 32'h1);
      m_stb[0] = 1'b1;
      for (int k = 1; k <= TMO; k++) begin
         #1;
         if (k < TMO) begin
            chk("t5b_no_rsp", 32'({m_ack, m_err}), 32'(0));
            nxt();
         end else begin
            s_ack[3] = 1'b1;
            #1;
            chk("t5b_ack", 32'(m_ack), 32'h1);
            chk("t5b_no_err", 32'(m_err), 32'(0));
            chk("t5b_stb", 32'(s_stb), 32'h8);
         end
      end
      nxt(); #1;
      chk("t5b_tcount", 32'(tcount), 32'h1);
      s_ack = '0; m_stb[0] = 1'b0; m_cyc[0] = 1'b0; m_adr = '0;
      nxt(); #1;
      chk("t5b_release", 32'(grant), 32'(0));
      ptr_m = 1;

      // Reset in the middle of a transfer
      m_cyc[0] = 1'b1;
      nxt(); #1;
      chk("t6_grant", 32'(grant), 32'h1);
      m_stb[0] = 1'b1; m_adr[0 +: AW] = 20'h1_0000;
      rst = 1'b1;
      nxt(); #1;
      chk("t6_grant_off", 32'(grant), 32'(0));
      chk("t6_s_cyc_off", 32'(s_cyc), 32'(0));
      chk("t6_s_stb_off", 32'(s_stb), 32'(0));
      s_ack[1] = 1'b1;
      #1;
      chk("t6_no_ack", 32'(m_ack), 32'(0));
      nxt(); #1;
      chk("t6_still_idle", 32'(grant), 32'(0));
      chk("t6_tcount", 32'(tcount), 32'(0));
      s_ack = '0; m_stb = '0; m_cyc = '0; m_adr = '0;
      rst = 1'b0;
      ptr_m = 0;

      // Randomized rounds
      for (int r = 0; r < 40; r++) begin
         serve(NM'($urandom_range(1, 7)), 3'b000, 2, 1, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
